// File: rtl/pkg_kyber.sv
// -----------------------------------------------------------------------------
// pkg_kyber
//   Shared Kyber arithmetic constants for the modular datapath (mult_k, red_K).
//
//   KYBER_Q        : Kyber modulus q = 3329
//   KYBER_NB_OP    : coefficient / operand width in bits
//   KYBER_NB_PROD  : raw product width, 2 * KYBER_NB_OP
//   KYBER_BARRETT  : Barrett constant floor(2^24 / q), consumed by red_K
// -----------------------------------------------------------------------------
package pkg_kyber;

    localparam int unsigned KYBER_Q       = 3329;
    localparam int unsigned KYBER_NB_OP   = 12;
    localparam int unsigned KYBER_NB_PROD = 2 * KYBER_NB_OP;
    localparam int unsigned KYBER_BARRETT = 5039;

endpackage : pkg_kyber

// File: rtl/mult_k_pipe_stage_n.sv
// -----------------------------------------------------------------------------
// pipe_stage_n
//   One elastic pipeline slice: a data register plus its valid flag.
//   When en_i is high the slice loads data_i/valid_i from upstream, otherwise
//   it holds. flush_i empties the slice on the next edge (data is don't-care).
//
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset (valid and data cleared)
//   flush_i  : synchronous flush, clears valid_o on the next edge
//   en_i     : stage enable (load from upstream)
//   data_i   : upstream data, nb_bit wide
//   valid_i  : upstream valid
//   data_o   : registered data
//   valid_o  : registered valid
// -----------------------------------------------------------------------------
module pipe_stage_n
    import pkg_kyber::*;
#(
    parameter int unsigned nb_bit = 24
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              en_i,
    input  logic [nb_bit-1:0] data_i,
    input  logic              valid_i,
    output logic [nb_bit-1:0] data_o,
    output logic              valid_o
);

    logic [nb_bit-1:0] data_q;
    logic [nb_bit-1:0] data_d;
    logic              valid_q;
    logic              valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en_i) begin
            data_d  = data_i;
            valid_d = valid_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule : pipe_stage_n

// File: rtl/mult_k.sv
// -----------------------------------------------------------------------------
// mult_k
//   Two-stage pipelined 12x12 unsigned multiplier for the Kyber NTT/basemul
//   datapath. Produces the full 24-bit raw product for the Barrett stage red_K,
//   one product per cycle, with valid/ready flow control on both sides and a
//   sticky flag for non-canonical operands (>= Q).
//
//   clk_i      : clock, rising edge
//   rst_n_i    : asynchronous active-low reset
//   flush_i    : synchronous flush of all in-flight products
//   a_i, b_i   : operands, NB_OP bits
//   valid_i    : operand pair valid
//   ready_o    : operand pair accepted this cycle (when valid_i)
//   product_o  : a*b, unsigned, NB_PROD bits
//   valid_o    : product_o valid
//   ready_i    : downstream accepts product_o
//   err_clr_i  : clears err_o (wins over a same-cycle set)
//   err_o      : sticky, an accepted operand was >= Q
// -----------------------------------------------------------------------------
module mult_k
    import pkg_kyber::*;
#(
    parameter int unsigned Q       = KYBER_Q,
    parameter int unsigned NB_OP   = KYBER_NB_OP,
    parameter int unsigned NB_PROD = KYBER_NB_PROD
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               flush_i,
    input  logic [NB_OP-1:0]   a_i,
    input  logic [NB_OP-1:0]   b_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [NB_PROD-1:0] product_o,
    output logic               valid_o,
    input  logic               ready_i,
    input  logic               err_clr_i,
    output logic               err_o
);

    localparam logic [NB_OP-1:0] Q_OP = NB_OP'(Q);

    // Stage 1: operand pair register
    logic [2*NB_OP-1:0] s1_data_in;
    logic [2*NB_OP-1:0] s1_data;
    logic               s1_valid;
    logic               s1_en;

    // Stage 2: product register, drives the outputs directly
    logic [NB_PROD-1:0] s2_data_in;
    logic [NB_PROD-1:0] s2_data;
    logic               s2_valid;
    logic               s2_en;

    logic [NB_OP-1:0]   a1;
    logic [NB_OP-1:0]   b1;

    logic               in_xfer;
    logic               op_bad;
    logic               err_q;
    logic               err_d;

    // Backpressure ripples from the output towards the input in one cycle;
    // an empty stage is always free to load.
    always_comb begin
        s2_en = !s2_valid || ready_i;
        s1_en = !s1_valid || s2_en;
    end

    assign ready_o    = s1_en;
    assign in_xfer    = valid_i && s1_en;
    assign s1_data_in = {a_i, b_i};

    assign a1 = s1_data[2*NB_OP-1:NB_OP];
    assign b1 = s1_data[NB_OP-1:0];

    always_comb begin
        s2_data_in = NB_PROD'(a1) * NB_PROD'(b1);
    end

    pipe_stage_n #(
        .nb_bit (2 * NB_OP)
    ) u_stage1 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .en_i    (s1_en),
        .data_i  (s1_data_in),
        .valid_i (valid_i),
        .data_o  (s1_data),
        .valid_o (s1_valid)
    );

    pipe_stage_n #(
        .nb_bit (NB_PROD)
    ) u_stage2 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .en_i    (s2_en),
        .data_i  (s2_data_in),
        .valid_i (s1_valid),
        .data_o  (s2_data),
        .valid_o (s2_valid)
    );

    assign product_o = s2_data;
    assign valid_o   = s2_valid;

    // Range check is on the accepted pair; the product itself is untouched.
    assign op_bad = (a_i >= Q_OP) || (b_i >= Q_OP);

    always_comb begin
        err_d = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end else if (in_xfer && op_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule : mult_k

// File: tb/tb_mult_k.sv
module tb_mult_k;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [11:0] a;
    logic [11:0] b;
    logic        valid_in;
    logic        ready_out;
    logic [23:0] product;
    logic        valid_out;
    logic        ready_in;
    logic        err_clr;
    logic        err;

    mult_k #(
        .Q       (3329),
        .NB_OP   (12),
        .NB_PROD (24)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .flush_i   (flush),
        .a_i       (a),
        .b_i       (b),
        .valid_i   (valid_in),
        .ready_o   (ready_out),
        .product_o (product),
        .valid_o   (valid_out),
        .ready_i   (ready_in),
        .err_clr_i (err_clr),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: the pipeline is a FIFO of at most two products. An item
    // becomes visible one edge after it was accepted, provided it is the oldest.
    typedef struct {
        int unsigned prod;
        int          age;
    } item_t;

    item_t mq[$];
    bit    m_err;
    bit    m_in;
    bit    m_out;
    bit    m_bad;

    function automatic bit exp_valid();
        return (mq.size() > 0) && (mq[0].age >= 1);
    endfunction

    function automatic bit exp_ready();
        return (mq.size() < 2) || ready_in;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            m_out = exp_valid() && ready_in;
            m_in  = valid_in && exp_ready();
            m_bad = (a >= 12'd3329) || (b >= 12'd3329);
            if (err_clr) m_err = 1'b0;
            else if (m_in && m_bad) m_err = 1'b1;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out) void'(mq.pop_front());
                foreach (mq[i]) mq[i].age++;
                if (m_in) mq.push_back('{prod: int'(a) * int'(b), age: 0});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_o", 32'(ready_out), 32'(exp_ready()));
            chk("valid_o", 32'(valid_out), 32'(exp_valid()));
            chk("err_o", 32'(err), 32'(m_err));
            if (exp_valid()) chk("product_o", 32'(product), mq[0].prod);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int unsigned av, input int unsigned bv);
        a        = 12'(av);
        b        = 12'(bv);
        valid_in = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        a        = '0;
        b        = '0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        err_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // reset state
        chk("rst valid_o", 32'(valid_out), 0);
        chk("rst product_o", 32'(product), 0);
        chk("rst err_o", 32'(err), 0);
        chk("rst ready_o", 32'(ready_out), 1);

        // single max canonical pair, 2-cycle latency
        drive(3328, 3328);
        step();
        valid_in = 1'b0;
        chk("lat1 valid_o", 32'(valid_out), 0);
        step();
        chk("lat2 valid_o", 32'(valid_out), 1);
        chk("lat2 product", 32'(product), 32'hA90000);
        chk("lat2 err_o", 32'(err), 0);
        step();
        chk("lat3 valid_o", 32'(valid_out), 0);

        // back-to-back stream a=k, b=2k
        for (int j = 1; j <= 10; j++) begin
            if (j <= 8) drive(j, 2 * j);
            else valid_in = 1'b0;
            chk("stream ready_o", 32'(ready_out), 1);
            step();
            if (j >= 2 && j <= 9) begin
                chk("stream valid_o", 32'(valid_out), 1);
                chk("stream product", 32'(product), 32'(2 * (j - 1) * (j - 1)));
            end else begin
                chk("stream idle", 32'(valid_out), 0);
            end
        end

        // backpressure: both stages fill, output held
        ready_in = 1'b0;
        drive(1234, 2);
        step();
        drive(5, 7);
        step();
        valid_in = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("bp valid_o", 32'(valid_out), 1);
            chk("bp product", 32'(product), 2468);
            chk("bp ready_o", 32'(ready_out), 0);
            step();
        end
        ready_in = 1'b1;
        #1;
        chk("bp ready_o released", 32'(ready_out), 1);
        chk("bp first", 32'(product), 2468);
        step();
        chk("bp second valid", 32'(valid_out), 1);
        chk("bp second", 32'(product), 35);
        step();
        chk("bp drained", 32'(valid_out), 0);

        // range error, sticky, clear, clear-vs-set priority
        drive(3329, 1);
        step();
        valid_in = 1'b0;
        chk("range err set", 32'(err), 1);
        step();
        chk("range product", 32'(product), 3329);
        step();
        chk("range err sticky", 32'(err), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("range err cleared", 32'(err), 0);
        drive(4000, 5);
        err_clr = 1'b1;
        step();
        valid_in = 1'b0;
        err_clr  = 1'b0;
        chk("clear beats set", 32'(err), 0);
        step();
        chk("noncanon product", 32'(product), 20000);
        step();

        // flush with two items stalled
        ready_in = 1'b0;
        drive(10, 11);
        step();
        drive(12, 13);
        step();
        valid_in = 1'b0;
        chk("flush pre valid", 32'(valid_out), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush valid_o", 32'(valid_out), 0);
        ready_in = 1'b1;
        drive(3, 4);
        step();
        valid_in = 1'b0;
        chk("post flush lat1", 32'(valid_out), 0);
        step();
        chk("post flush valid", 32'(valid_out), 1);
        chk("post flush product", 32'(product), 12);
        step();
        chk("post flush alone", 32'(valid_out), 0);

        // asynchronous reset between edges
        ready_in = 1'b0;
        drive(4095, 1);
        step();
        drive(7, 8);
        step();
        valid_in = 1'b0;
        chk("pre-reset err", 32'(err), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst valid_o", 32'(valid_out), 0);
        chk("async rst err_o", 32'(err), 0);
        chk("async rst ready_o", 32'(ready_out), 1);
        step();
        #1;
        rst_n = 1'b1;
        step();
        chk("after rst ready_o", 32'(ready_out), 1);
        chk("after rst valid_o", 32'(valid_out), 0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            valid_in = ($urandom_range(0, 9) < 7);
            ready_in = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 99) < 3);
            err_clr  = ($urandom_range(0, 99) < 5);
            if (!flush && $urandom_range(0, 9) == 0) a = 12'($urandom_range(3329, 4095));
            else a = 12'($urandom_range(0, 3328));
            if (!flush && $urandom_range(0, 9) == 0) b = 12'($urandom_range(3329, 4095));
            else b = 12'($urandom_range(0, 3328));
            step();
        end
        valid_in = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
        ready_in = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mult_k
